// File: rtl/acc_alu_multicycle.sv
// acc_alu_multicycle: 8085-style accumulator/ALU with Z/CY/S/P flags.
// Ports: clk, reset, start/op/operand in; busy, done, acc, prod_hi, z/cy/s/p out.
module acc_alu_multicycle #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] prod_hi,
  output logic             z,
  output logic             cy,
  output logic             s,
  output logic             p
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] opd_q;
  logic [WIDTH-1:0] hi, lo;
  logic [CW-1:0]    cnt;
  logic             mul_last;

  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res;
  logic             upd_acc, upd_f, ncy, clr_hi;
  logic [WIDTH:0]   msum;

  assign mul_last = (cnt == CW'(WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (op == OP_MUL) ? MUL : EXEC;
      end
      EXEC: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      MUL: begin
        if (mul_last) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // res feeds the flags for every flag-setting op; acc only takes it
  // when upd_acc is set (CMP sets flags but keeps acc).
  always_comb begin
    ext     = '0;
    res     = acc;
    upd_acc = 1'b0;
    upd_f   = 1'b0;
    ncy     = cy;
    clr_hi  = (op_q != 4'h0) && (op_q < OP_MUL);
    case (op_q)
      4'h1: begin
        res     = opd_q;
        upd_acc = 1'b1;
      end
      4'h2, 4'h3: begin
        ext = {1'b0, acc} + {1'b0, opd_q}
            + {{WIDTH{1'b0}}, (op_q == 4'h3) & cy};
        res     = ext[WIDTH-1:0];
        ncy     = ext[WIDTH];
        upd_acc = 1'b1;
        upd_f   = 1'b1;
      end
      4'h4, 4'h5, 4'h9: begin
        // 9-bit difference: bit WIDTH is the borrow
        ext = {1'b0, acc} - {1'b0, opd_q}
            - {{WIDTH{1'b0}}, (op_q == 4'h5) & cy};
        res     = ext[WIDTH-1:0];
        ncy     = ext[WIDTH];
        upd_acc = (op_q != 4'h9);
        upd_f   = 1'b1;
      end
      4'h6, 4'h7, 4'h8: begin
        unique case (1'b1)
          op_q == 4'h6: res = acc & opd_q;
          op_q == 4'h7: res = acc | opd_q;
          default:      res = acc ^ opd_q;
        endcase
        ncy     = 1'b0;
        upd_acc = 1'b1;
        upd_f   = 1'b1;
      end
      4'hA, 4'hB: begin
        res     = (op_q == 4'hA) ? acc + 1'b1 : acc - 1'b1;
        upd_acc = 1'b1;
        upd_f   = 1'b1;
      end
      4'hC: begin
        res     = {acc[WIDTH-2:0], acc[WIDTH-1]};
        ncy     = acc[WIDTH-1];
        upd_acc = 1'b1;
        upd_f   = 1'b1;
      end
      4'hD: begin
        res     = {acc[0], acc[WIDTH-1:1]};
        ncy     = acc[0];
        upd_acc = 1'b1;
        upd_f   = 1'b1;
      end
      default: ;
    endcase
  end

  // lo holds the multiplier (old acc) and is shifted out as hi grows
  assign msum = {1'b0, hi} + (lo[0] ? {1'b0, opd_q} : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= ACC_INIT;
      prod_hi <= '0;
      z       <= 1'b0;
      cy      <= 1'b0;
      s       <= 1'b0;
      p       <= 1'b0;
      op_q    <= '0;
      opd_q   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            opd_q <= operand;
            cnt   <= '0;
          end
        end
        EXEC: begin
          if (upd_acc) acc <= res;
          if (upd_f) begin
            z  <= (res == '0);
            s  <= res[WIDTH-1];
            p  <= ~^res;
            cy <= ncy;
          end
          if (clr_hi) prod_hi <= '0;
        end
        MUL: begin
          // first MUL cycle loads the working pair, then WIDTH steps
          if (cnt == '0) begin
            hi <= '0;
            lo <= acc;
          end else begin
            {hi, lo} <= {msum, lo[WIDTH-1:1]};
          end
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          acc     <= lo;
          prod_hi <= hi;
          z       <= ({hi, lo} == '0);
          cy      <= (hi != '0);
          s       <= lo[WIDTH-1];
          p       <= ~^lo;
        end
        default: ;
      endcase
    end
  end

endmodule
